// File: rtl/muldiv_seq.sv
// Iterative HI/LO unit: MULT/MULTU by shift-add and DIV/DIVU by restoring division on a borrowed ALU.
// Latency: multiply 34+2*popcount(|rt|), divide 66+popcount(|quotient|), divide by zero 2 (done cycle, start = cycle 0).
// Backpressure: every requesting state holds its state and ALU operands until alu_gnt; each ungranted cycle adds one.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start, op, opa, opb   launch (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV), accepted only when idle
//   flush                 cancel the in-flight operation, leaving hi/lo untouched
//   hi_we, lo_we, wdata   MTHI/MTLO writes, honoured only while idle
//   busy, done, hi, lo    status, one-cycle completion pulse, architectural HI/LO
//   alu_req/gnt/a/b/fncode/r  shared ALU handshake; alu_r is combinational in the same cycle

package muldiv_pkg;
    typedef enum logic [5:0] {
        FUNCT_ADDU = 6'h21,
        FUNCT_SUBU = 6'h23,
        FUNCT_SLTU = 6'h2b
    } funct_t;
endpackage

module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output funct_t      alu_fncode,
    input  logic [31:0] alu_r
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_TEST,
        MUL_ADD,
        MUL_CARRY,
        DIV_SHIFT,
        DIV_CMP,
        DIV_SUB,
        FIXUP
    } state_t;

    state_t      state;
    // acc_hi/acc_lo hold {P,L} while multiplying and {R,Q} while dividing.
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic        m;          // bit shifted out of R: remainder is {m,R}
    logic [31:0] t;          // P+A sum waiting for its carry test
    logic [5:0]  cnt;
    logic [31:0] opnd;       // A (multiplicand) or D (divisor) magnitude
    logic        is_div;
    logic        neg_res;    // operand signs differ
    logic        neg_rem;    // dividend negative

    state_t      nxt_state;
    logic [31:0] nxt_acc_hi;
    logic [31:0] nxt_acc_lo;
    logic        nxt_m;
    logic [31:0] nxt_t;
    logic [5:0]  nxt_cnt;
    logic [31:0] nxt_opnd;
    logic        nxt_is_div;
    logic        nxt_neg_res;
    logic        nxt_neg_rem;
    logic        nxt_busy;
    logic        nxt_done;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;
    logic        nxt_alu_req;
    logic [31:0] nxt_alu_a;
    logic [31:0] nxt_alu_b;
    funct_t      nxt_alu_fn;

    // Operand magnitudes: only the signed ops (op[0]=1) look at bit 31.
    // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        last_iter;
    logic [63:0] prod_neg;

    assign a_neg     = op[0] & opa[31];
    assign b_neg     = op[0] & opb[31];
    assign a_mag     = a_neg ? (~opa + 32'd1) : opa;
    assign b_mag     = b_neg ? (~opb + 32'd1) : opb;
    assign last_iter = (cnt == 6'd31);
    assign prod_neg  = ~{acc_hi, acc_lo} + 64'd1;

    always_comb begin
        nxt_state   = state;
        nxt_acc_hi  = acc_hi;
        nxt_acc_lo  = acc_lo;
        nxt_m       = m;
        nxt_t       = t;
        nxt_cnt     = cnt;
        nxt_opnd    = opnd;
        nxt_is_div  = is_div;
        nxt_neg_res = neg_res;
        nxt_neg_rem = neg_rem;
        nxt_busy    = busy;
        nxt_done    = 1'b0;
        nxt_hi      = hi;
        nxt_lo      = lo;

        case (state)
            IDLE: begin
                if (hi_we) nxt_hi = wdata;
                if (lo_we) nxt_lo = wdata;
                if (start) begin
                    nxt_busy    = 1'b1;
                    nxt_cnt     = 6'd0;
                    nxt_m       = 1'b0;
                    nxt_neg_res = a_neg ^ b_neg;
                    nxt_neg_rem = a_neg;
                    nxt_is_div  = op[1];
                    if (!op[1]) begin
                        nxt_opnd   = a_mag;
                        nxt_acc_hi = 32'd0;
                        nxt_acc_lo = b_mag;
                        nxt_state  = MUL_TEST;
                    end else if (b_mag == 32'd0) begin
                        // Divide by zero: fixed all-ones quotient, dividend as remainder.
                        nxt_opnd   = b_mag;
                        nxt_acc_hi = a_mag;
                        nxt_acc_lo = 32'hFFFF_FFFF;
                        nxt_state  = FIXUP;
                    end else begin
                        nxt_opnd   = b_mag;
                        nxt_acc_hi = 32'd0;
                        nxt_acc_lo = a_mag;
                        nxt_state  = DIV_SHIFT;
                    end
                end
            end

            MUL_TEST: begin
                if (!acc_lo[0]) begin
                    nxt_acc_hi = {1'b0, acc_hi[31:1]};
                    nxt_acc_lo = {acc_hi[0], acc_lo[31:1]};
                    nxt_cnt    = cnt + 6'd1;
                    nxt_state  = last_iter ? FIXUP : MUL_TEST;
                end else begin
                    nxt_state = MUL_ADD;
                end
            end

            MUL_ADD: begin
                if (alu_gnt) begin
                    nxt_t     = alu_r;
                    nxt_state = MUL_CARRY;
                end
            end

            MUL_CARRY: begin
                // The sum wrapped iff it is below the addend; that bit becomes the new P[31].
                if (alu_gnt) begin
                    nxt_acc_hi = {alu_r[0], t[31:1]};
                    nxt_acc_lo = {t[0], acc_lo[31:1]};
                    nxt_cnt    = cnt + 6'd1;
                    nxt_state  = last_iter ? FIXUP : MUL_TEST;
                end
            end

            DIV_SHIFT: begin
                nxt_m      = acc_hi[31];
                nxt_acc_hi = {acc_hi[30:0], acc_lo[31]};
                nxt_acc_lo = {acc_lo[30:0], 1'b0};
                nxt_state  = DIV_CMP;
            end

            DIV_CMP: begin
                // With m set the 33-bit remainder always exceeds D, whatever SLTU says.
                if (alu_gnt) begin
                    if (m || !alu_r[0]) begin
                        nxt_state = DIV_SUB;
                    end else begin
                        nxt_cnt   = cnt + 6'd1;
                        nxt_state = last_iter ? FIXUP : DIV_SHIFT;
                    end
                end
            end

            DIV_SUB: begin
                // The true difference is below D, so the 32-bit wrap drops only m.
                if (alu_gnt) begin
                    nxt_acc_hi    = alu_r;
                    nxt_acc_lo[0] = 1'b1;
                    nxt_m         = 1'b0;
                    nxt_cnt       = cnt + 6'd1;
                    nxt_state     = last_iter ? FIXUP : DIV_SHIFT;
                end
            end

            FIXUP: begin
                if (is_div) begin
                    nxt_lo = neg_res ? (~acc_lo + 32'd1) : acc_lo;
                    nxt_hi = neg_rem ? (~acc_hi + 32'd1) : acc_hi;
                end else if (neg_res) begin
                    nxt_hi = prod_neg[63:32];
                    nxt_lo = prod_neg[31:0];
                end else begin
                    nxt_hi = acc_hi;
                    nxt_lo = acc_lo;
                end
                nxt_busy  = 1'b0;
                nxt_done  = 1'b1;
                nxt_state = IDLE;
            end

            default: begin
                nxt_state = IDLE;
                nxt_busy  = 1'b0;
            end
        endcase

        // Flush beats start; an in-flight result is discarded, idle writes still land.
        if (flush) begin
            nxt_state = IDLE;
            nxt_busy  = 1'b0;
            nxt_done  = 1'b0;
            if (state != IDLE) begin
                nxt_hi = hi;
                nxt_lo = lo;
            end
        end
    end

    // ALU outputs are registered from the state being entered, so they are
    // valid for the whole requesting cycle and frozen while the grant is withheld.
    always_comb begin
        nxt_alu_req = 1'b0;
        nxt_alu_a   = 32'd0;
        nxt_alu_b   = 32'd0;
        nxt_alu_fn  = FUNCT_ADDU;
        case (nxt_state)
            MUL_ADD: begin
                nxt_alu_req = 1'b1;
                nxt_alu_a   = nxt_acc_hi;
                nxt_alu_b   = nxt_opnd;
                nxt_alu_fn  = FUNCT_ADDU;
            end
            MUL_CARRY: begin
                nxt_alu_req = 1'b1;
                nxt_alu_a   = nxt_t;
                nxt_alu_b   = nxt_opnd;
                nxt_alu_fn  = FUNCT_SLTU;
            end
            DIV_CMP: begin
                nxt_alu_req = 1'b1;
                nxt_alu_a   = nxt_acc_hi;
                nxt_alu_b   = nxt_opnd;
                nxt_alu_fn  = FUNCT_SLTU;
            end
            DIV_SUB: begin
                nxt_alu_req = 1'b1;
                nxt_alu_a   = nxt_acc_hi;
                nxt_alu_b   = nxt_opnd;
                nxt_alu_fn  = FUNCT_SUBU;
            end
            default: begin
                nxt_alu_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc_hi     <= 32'd0;
            acc_lo     <= 32'd0;
            m          <= 1'b0;
            t          <= 32'd0;
            cnt        <= 6'd0;
            opnd       <= 32'd0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            alu_req    <= 1'b0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_fncode <= FUNCT_ADDU;
        end else begin
            state      <= nxt_state;
            acc_hi     <= nxt_acc_hi;
            acc_lo     <= nxt_acc_lo;
            m          <= nxt_m;
            t          <= nxt_t;
            cnt        <= nxt_cnt;
            opnd       <= nxt_opnd;
            is_div     <= nxt_is_div;
            neg_res    <= nxt_neg_res;
            neg_rem    <= nxt_neg_rem;
            busy       <= nxt_busy;
            done       <= nxt_done;
            hi         <= nxt_hi;
            lo         <= nxt_lo;
            alu_req    <= nxt_alu_req;
            alu_a      <= nxt_alu_a;
            alu_b      <= nxt_alu_b;
            alu_fncode <= nxt_alu_fn;
        end
    end

endmodule
